mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the data, address and PC width; only 64 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-high reset (asserted when 1).
REQ-004 SHALL have port clear, input, 1: pipeline flush.
REQ-005 SHALL have port trap_en, input, 1: trap taken; kill the current op.
REQ-006 SHALL have port io_load, input, 1: the op is a load.
REQ-007 SHALL have port io_store, input, 1: the op is a store.
REQ-008 SHALL have port io_size, input, 2: 0=byte, 1=half, 2=word, 3=double.
REQ-009 SHALL have port io_unsigned, input, 1: zero-extend the load.
REQ-010 SHALL have port io_sfence, input, 1: TLB-invalidate op.
REQ-011 SHALL have ports pc, input, 64 and rd, input, 5: the MA-stage PC and destination register.
REQ-012 SHALL have port result, input, 64: ALU result, used as the memory address for loads and stores.
REQ-013 SHALL have port data2, input, 64: store data.
REQ-014 SHALL have ports csr_data, input, 64 and op_csr, input, 1: CSR read value and its valid flag.
REQ-015 SHALL have port invalid, output, 1: TLB/MMU invalidate strobe.
REQ-016 SHALL have port ma_out, output, 64: combinational forwarding value.
REQ-017 SHALL have ports pc_out, output, 64; rd_out, output, 5; data_out, output, 64: the registered WB-stage values.
REQ-018 SHALL have ports stall, output, 1 and request, output, 1: pipeline hold and bus-ownership request.
REQ-019 SHALL have bus A-channel ports:
- a_valid, output, 1; a_ready, input, 1
- a_opcode, output, 3; a_size, output, 2
- a_address, output, 64; a_mask, output, 8; a_data, output, 64
REQ-020 SHALL have bus D-channel ports d_valid, input, 1; d_ready, output, 1; d_data, input, 64.

Function
REQ-021 SHALL implement FSM states IDLE, ADDR, DATA and DRAIN.
REQ-022 SHALL define mem_op = (io_load | io_store) & ~trap_en & ~clear.
REQ-023 SHALL assert a_valid = mem_op & (state is IDLE or ADDR).
- IDLE→ADDR when a_valid & ~a_ready.
- IDLE or ADDR→DATA on a_valid & a_ready.
REQ-024 SHALL drive a_opcode = 4 (Get) for loads; for stores, 0 (PutFull) when io_size=3, else 1 (PutPartial).
REQ-025 SHALL drive a_address = result, a_size = io_size, and a_mask = ((1<<(1<<io_size))-1) << result[2:0].
REQ-026 SHALL drive a_data = data2 << (8*result[2:0]); misaligned accesses are not checked here.
REQ-027 SHALL drive d_ready=1 in DATA and DRAIN, and 0 in IDLE and ADDR.
REQ-028 SHALL, in DATA on d_valid, go to IDLE with resp_done=1 for that cycle.
REQ-029 SHALL form load data as d_data >> (8*result[2:0]), truncated to io_size and sign- or zero-extended per io_unsigned.
REQ-030 SHALL drive stall = (mem_op & ~resp_done) | state==DRAIN.
REQ-031 SHALL drive request = a_valid | state==DATA | state==DRAIN.
REQ-032 SHALL drive ma_out as:
- csr_data if op_csr
- else extended load data if io_load & resp_done
- else result.
REQ-033 SHALL drive invalid = io_sfence & ~trap_en & ~clear, combinationally, for one cycle.
REQ-034 SHALL handle trap_en or clear by state:
- in ADDR: return to IDLE, a_valid dropped.
- in DATA: go to DRAIN, discard the next d_valid beat, then IDLE.
REQ-035 SHALL, on each clock edge, write the WB registers as:
- if trap_en|clear: pc_out, rd_out and data_out ← 0
- else if stall: rd_out ← 0 (bubble), pc_out ← 0
- else: pc_out ← pc, rd_out ← rd, data_out ← ma_out.
REQ-036 SHALL let a store write rd_out = rd as supplied (0 from decode); writes to x0 are not filtered.

Reset
REQ-037 SHALL, while rst_n=1, asynchronously force state=IDLE and pc_out, rd_out, data_out to 0.
REQ-038 SHALL hold all combinational outputs (a_valid, stall, request, invalid) at 0 during reset when there is no op; reset mid-transaction abandons it without draining.

Verification
REQ-039 SHALL pass this check:
- stimulus: ALU op with result=0x1234, rd=5, no mem, op_csr=0
- response: ma_out=0x1234; next edge rd_out=5, data_out=0x1234, stall never high.
REQ-040 SHALL pass this check:
- stimulus: load byte signed, result=0x8003, d_data=0x00000000_80000000 one cycle after a_ready
- response: a_opcode=4, a_mask=0x08, stall high until the d_valid cycle, data_out=0xFFFF_FFFF_FFFF_FF80.
REQ-041 SHALL pass this check:
- stimulus: store half, result=0x1002, data2=0xBEEF
- response: a_opcode=1, a_mask=0x0C, a_data=0x0000_0000_BEEF_0000, rd_out=0 while stalled.
REQ-042 SHALL pass this check:
- stimulus: op_csr=1, csr_data=0xABCD, result=7
- response: ma_out=0xABCD, data_out=0xABCD next edge.
REQ-043 SHALL pass this check:
- stimulus: trap_en during DATA with a load pending
- response: state DRAIN; stall=1, request=1 until d_valid; that data discarded; rd_out=0.
REQ-044 SHALL pass this check:
- stimulus: io_sfence=1 one cycle
- response: invalid=1 that cycle only; with trap_en=1, invalid=0.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage.
// Sends loads and stores on a request/response bus: the A channel carries the
// request and the D channel returns the response. The stage holds the pipeline
// until the response arrives. Load data is aligned and extended here, and the
// registered write-back values are produced for the WB stage.
module mem_access #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,        // asynchronous, active-high reset
  input  logic            clear,
  input  logic            trap_en,
  input  logic            io_load,
  input  logic            io_store,
  input  logic [1:0]      io_size,
  input  logic            io_unsigned,
  input  logic            io_sfence,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] csr_data,
  input  logic            op_csr,
  output logic            invalid,
  output logic [XLEN-1:0] ma_out,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] data_out,
  output logic            stall,
  output logic            request,
  output logic            a_valid,
  input  logic            a_ready,
  output logic [2:0]      a_opcode,
  output logic [1:0]      a_size,
  output logic [XLEN-1:0] a_address,
  output logic [7:0]      a_mask,
  output logic [XLEN-1:0] a_data,
  input  logic            d_valid,
  output logic            d_ready,
  input  logic [XLEN-1:0] d_data
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_kill;
  logic              w_mem_op;
  logic              w_resp_done;
  logic [5:0]        w_shamt;
  logic [7:0]        w_mask_base;
  logic [XLEN-1:0]   w_load_shifted;
  logic [XLEN-1:0]   w_load_ext;

  assign w_kill   = trap_en | clear;
  assign w_mem_op = (io_load | io_store) & ~w_kill;
  assign w_shamt  = {result[2:0], 3'b000};

  // State register. Reset abandons any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic for the bus handshake, including trap/flush handling.
  // NOTE: each combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (a_valid) w_next_state = a_ready ? DATA : ADDR;
      end
      ADDR: begin
        // A request that is no longer valid (killed or withdrawn) is abandoned.
        if (!w_mem_op)    w_next_state = IDLE;
        else if (a_ready) w_next_state = DATA;
      end
      DATA: begin
        // A beat arriving together with a kill consumes the response, so there is nothing left to drain.
        if (d_valid)     w_next_state = IDLE;
        else if (w_kill) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (d_valid) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake and pipeline-control outputs decoded from the state.
  always_comb begin
    a_valid     = w_mem_op & ((r_state == IDLE) | (r_state == ADDR));
    d_ready     = (r_state == DATA) | (r_state == DRAIN);
    w_resp_done = (r_state == DATA) & d_valid;
    stall       = (w_mem_op & ~w_resp_done) | (r_state == DRAIN);
    request     = a_valid | (r_state == DATA) | (r_state == DRAIN);
    invalid     = io_sfence & ~w_kill;
  end

  // Request formatting, load-data alignment/extension and the forwarding mux.
  always_comb begin
    a_address = result;
    a_size    = io_size;
    if (io_load)            a_opcode = 3'd4;  // Get
    else if (io_size == 2'd3) a_opcode = 3'd0;  // PutFull
    else                    a_opcode = 3'd1;  // PutPartial
    unique case (io_size)
      2'd0:    w_mask_base = 8'h01;
      2'd1:    w_mask_base = 8'h03;
      2'd2:    w_mask_base = 8'h0F;
      default: w_mask_base = 8'hFF;
    endcase
    a_mask = w_mask_base << result[2:0];
    a_data = data2 << w_shamt;

    w_load_shifted = d_data >> w_shamt;
    unique case (io_size)
      2'd0: w_load_ext = io_unsigned ? {{(XLEN-8){1'b0}}, w_load_shifted[7:0]}
                                     : {{(XLEN-8){w_load_shifted[7]}}, w_load_shifted[7:0]};
      2'd1: w_load_ext = io_unsigned ? {{(XLEN-16){1'b0}}, w_load_shifted[15:0]}
                                     : {{(XLEN-16){w_load_shifted[15]}}, w_load_shifted[15:0]};
      2'd2: w_load_ext = io_unsigned ? {{(XLEN-32){1'b0}}, w_load_shifted[31:0]}
                                     : {{(XLEN-32){w_load_shifted[31]}}, w_load_shifted[31:0]};
      default: w_load_ext = w_load_shifted;
    endcase

    if (op_csr)                      ma_out = csr_data;
    else if (io_load && w_resp_done) ma_out = w_load_ext;
    else                             ma_out = result;
  end

  // Write-back registers: zero on kill, bubble while stalled, else pass the stage through.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_out   <= '0;
      rd_out   <= '0;
      data_out <= '0;
    end else if (w_kill) begin
      pc_out   <= '0;
      rd_out   <= '0;
      data_out <= '0;
    end else if (stall) begin
      pc_out   <= '0;
      rd_out   <= '0;
    end else begin
      pc_out   <= pc;
      rd_out   <= rd;
      data_out <= ma_out;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: ALU pass-through, loads of all
// sizes and alignments, stores, CSR forwarding, trap/flush kill, sfence strobe
// and asynchronous reset in the middle of a transaction.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0, trap_en = 1'b0;
  logic        io_load = 1'b0, io_store = 1'b0, io_unsigned = 1'b0, io_sfence = 1'b0;
  logic [1:0]  io_size = 2'd0;
  logic [63:0] pc = '0, result = '0, data2 = '0, csr_data = '0, d_data = '0;
  logic [4:0]  rd = '0;
  logic        op_csr = 1'b0, a_ready = 1'b0, d_valid = 1'b0;

  logic        invalid, stall, request, a_valid, d_ready;
  logic [63:0] ma_out, pc_out, data_out, a_address, a_data;
  logic [4:0]  rd_out;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_mask;

  int n_checks = 0;
  int n_errors = 0;

  mem_access #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .trap_en(trap_en),
    .io_load(io_load), .io_store(io_store), .io_size(io_size),
    .io_unsigned(io_unsigned), .io_sfence(io_sfence),
    .pc(pc), .rd(rd), .result(result), .data2(data2),
    .csr_data(csr_data), .op_csr(op_csr),
    .invalid(invalid), .ma_out(ma_out), .pc_out(pc_out), .rd_out(rd_out),
    .data_out(data_out), .stall(stall), .request(request),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 ns past the edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                         input logic [63:0] rdata, input logic [63:0] exp,
                         input logic [7:0] exp_mask, input int wait_cycles);
    io_load = 1'b1; io_size = size; io_unsigned = uns; result = addr;
    rd = 5'd10; pc = 64'h200;
    a_ready = (wait_cycles == 0);
    #1;
    check("ld_a_valid", a_valid, 1);
    check("ld_opcode", a_opcode, 3'd4);
    check("ld_mask", a_mask, exp_mask);
    check("ld_addr", a_address, addr);
    check("ld_stall", stall, 1);
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      check("ld_addr_wait_valid", a_valid, 1);
      check("ld_addr_wait_dready", d_ready, 0);
      if (i == wait_cycles - 1) a_ready = 1'b1;
    end
    tick();
    a_ready = 1'b0;
    #1;
    check("ld_data_dready", d_ready, 1);
    check("ld_data_avalid", a_valid, 0);
    check("ld_data_stall", stall, 1);
    check("ld_bubble_rd", rd_out, 0);
    d_valid = 1'b1; d_data = rdata;
    #1;
    check("ld_ma_out", ma_out, exp);
    check("ld_stall_release", stall, 0);
    tick();
    io_load = 1'b0; d_valid = 1'b0;
    check("ld_data_out", data_out, exp);
    check("ld_rd_out", rd_out, 10);
    #1;
  endtask

  task automatic do_store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wdata,
                          input logic [2:0] exp_op, input logic [7:0] exp_mask,
                          input logic [63:0] exp_data);
    io_store = 1'b1; io_size = size; result = addr; data2 = wdata; rd = 5'd0;
    a_ready = 1'b1;
    #1;
    check("st_opcode", a_opcode, exp_op);
    check("st_mask", a_mask, exp_mask);
    check("st_data", a_data, exp_data);
    check("st_size", a_size, size);
    tick();
    a_ready = 1'b0;
    #1;
    check("st_wait_stall", stall, 1);
    check("st_wait_rd", rd_out, 0);
    d_valid = 1'b1;
    #1;
    check("st_ack_stall", stall, 0);
    check("st_ma_out", ma_out, addr);
    tick();
    io_store = 1'b0; d_valid = 1'b0;
    check("st_rd_out", rd_out, 0);
    check("st_data_out", data_out, addr);
    #1;
  endtask

  initial begin
    // Reset: registered outputs forced to zero even with live pipeline inputs.
    #1 rst_n = 1'b1;
    pc = 64'h100; rd = 5'd3; result = 64'h55;
    tick(); tick();
    check("rst_pc_out", pc_out, 0);
    check("rst_rd_out", rd_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_request", request, 0);
    check("rst_invalid", invalid, 0);
    check("rst_d_ready", d_ready, 0);
    rst_n = 1'b0;

    // ALU op: forward result, write back next edge, never stall.
    pc = 64'h40; result = 64'h1234; rd = 5'd5;
    #1;
    check("alu_ma_out", ma_out, 64'h1234);
    check("alu_stall", stall, 0);
    tick();
    check("alu_rd_out", rd_out, 5);
    check("alu_data_out", data_out, 64'h1234);
    check("alu_pc_out", pc_out, 64'h40);
    check("alu_stall_after", stall, 0);

    // Loads across sizes, alignments and extension modes.
    do_load(64'h8003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h08, 0);
    do_load(64'h2006, 2'd1, 1'b1, 64'hABCD_0000_0000_0000, 64'h0000_0000_0000_ABCD, 8'hC0, 2);
    do_load(64'h3004, 2'd2, 1'b0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 8'hF0, 0);
    do_load(64'h4000, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hFF, 1);

    // Stores: PutPartial vs PutFull, lane shifting of data and mask.
    do_store(64'h1002, 2'd1, 64'hBEEF, 3'd1, 8'h0C, 64'h0000_0000_BEEF_0000);
    do_store(64'h1000, 2'd3, 64'h1122_3344_5566_7788, 3'd0, 8'hFF, 64'h1122_3344_5566_7788);
    do_store(64'h1005, 2'd0, 64'hAA, 3'd1, 8'h20, 64'h0000_AA00_0000_0000);

    // CSR value wins over the ALU result.
    op_csr = 1'b1; csr_data = 64'hABCD; result = 64'h7; rd = 5'd2; pc = 64'h80;
    #1;
    check("csr_ma_out", ma_out, 64'hABCD);
    tick();
    check("csr_data_out", data_out, 64'hABCD);
    check("csr_rd_out", rd_out, 2);
    op_csr = 1'b0;

    // Trap during DATA: drain one beat, discard it, bubble WB.
    io_load = 1'b1; io_size = 2'd3; result = 64'h5000; rd = 5'd9; a_ready = 1'b1;
    tick();
    a_ready = 1'b0; trap_en = 1'b1;
    #1;
    check("trap_data_request", request, 1);
    tick();
    trap_en = 1'b0; io_load = 1'b0; result = 64'h77;
    #1;
    check("drain_stall", stall, 1);
    check("drain_request", request, 1);
    check("drain_d_ready", d_ready, 1);
    check("drain_a_valid", a_valid, 0);
    check("drain_rd_out", rd_out, 0);
    check("drain_data_out", data_out, 0);
    tick();
    check("drain_hold_stall", stall, 1);
    d_valid = 1'b1; d_data = 64'hDEAD;
    #1;
    check("drain_beat_stall", stall, 1);
    check("drain_beat_ma_out", ma_out, 64'h77);
    tick();
    d_valid = 1'b0;
    #1;
    check("drain_discard_data", data_out, 0);
    check("drain_discard_rd", rd_out, 0);
    check("drain_exit_stall", stall, 0);
    check("drain_exit_request", request, 0);
    check("drain_exit_d_ready", d_ready, 0);

    // Clear while waiting in ADDR drops the request.
    io_load = 1'b1; io_size = 2'd0; result = 64'h6000;
    tick();
    check("addr_a_valid", a_valid, 1);
    clear = 1'b1;
    #1;
    check("addr_clear_a_valid", a_valid, 0);
    check("addr_clear_request", request, 0);
    tick();
    clear = 1'b0; io_load = 1'b0;
    #1;
    check("addr_clear_d_ready", d_ready, 0);
    check("addr_clear_rd_out", rd_out, 0);

    // sfence strobe, and its suppression by trap and clear.
    io_sfence = 1'b1;
    #1;
    check("sfence_invalid", invalid, 1);
    tick();
    io_sfence = 1'b0;
    #1;
    check("sfence_one_cycle", invalid, 0);
    io_sfence = 1'b1; trap_en = 1'b1;
    #1;
    check("sfence_trap", invalid, 0);
    trap_en = 1'b0; clear = 1'b1;
    #1;
    check("sfence_clear", invalid, 0);
    clear = 1'b0; io_sfence = 1'b0;
    tick();

    // Asynchronous reset in DATA abandons the transaction without draining.
    io_load = 1'b1; io_size = 2'd3; result = 64'h7000; a_ready = 1'b1; rd = 5'd4;
    tick();
    a_ready = 1'b0; io_load = 1'b0;
    #1;
    check("pre_rst_d_ready", d_ready, 1);
    rst_n = 1'b1;
    #1;
    check("mid_rst_d_ready", d_ready, 0);
    check("mid_rst_request", request, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_rd_out", rd_out, 0);
    tick();
    rst_n = 1'b0;
    tick();
    check("post_rst_stall", stall, 0);
    check("post_rst_d_ready", d_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
